// File: rtl/sc2110_roi_crop_module.sv
// Crop of the SC2110 pixel stream to a fixed rectangular region, with frame start/done pulses.
// Define SC2110_ROI_STATS_EN to build the line-width / frame-height / geometry-error measurement.
module sc2110_roi_crop_module #(
   parameter int DW      = 12,
   parameter int CNT_W   = 12,
   parameter int H_START = 0,
   parameter int H_SIZE  = 1920,
   parameter int V_START = 0,
   parameter int V_SIZE  = 1080
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_fvld,
   input  logic             i_lvld,
   input  logic             i_dvld,
   input  logic [DW-1:0]    i_data,
   output logic             o_fvld,
   output logic             o_lvld,
   output logic             o_dvld,
   output logic [DW-1:0]    o_data,
   output logic             o_frame_start,
   output logic             o_frame_done,
   output logic [CNT_W-1:0] o_width,
   output logic [CNT_W-1:0] o_height,
   output logic             o_err
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FRAME} state_t;

   // Window bounds carry one extra bit so START+SIZE cannot wrap.
   localparam logic [CNT_W:0] HS = (CNT_W+1)'(H_START);
   localparam logic [CNT_W:0] HE = (CNT_W+1)'(H_START + H_SIZE);
   localparam logic [CNT_W:0] VS = (CNT_W+1)'(V_START);
   localparam logic [CNT_W:0] VE = (CNT_W+1)'(V_START + V_SIZE);

   state_t           state_q;
   logic [CNT_W-1:0] x_q, x_d, y_q, y_d, x_cur, y_cur;
   logic             lvld_q;
   logic             start, active, frame_end, beat, line_end, lvld_fall, x_in, y_in;

   always_comb begin
      // ST_WAIT is only entered with i_fvld low, so i_fvld high here is a rising edge.
      start     = (state_q == ST_WAIT) & i_fvld;
      active    = (state_q == ST_FRAME) | start;
      frame_end = (state_q == ST_FRAME) & ~i_fvld;
      beat      = active & i_fvld & i_lvld & i_dvld;
      lvld_fall = lvld_q & ~i_lvld;
      line_end  = (state_q == ST_FRAME) & lvld_fall;
      x_cur     = start ? '0 : x_q;
      y_cur     = start ? '0 : y_q;
      x_in      = ({1'b0, x_cur} >= HS) && ({1'b0, x_cur} < HE);
      y_in      = ({1'b0, y_cur} >= VS) && ({1'b0, y_cur} < VE);
      x_d = x_cur;
      if (beat) begin
         if (x_cur != '1) x_d = x_cur + 1'b1;
      end else if (lvld_fall) begin
         x_d = '0;
      end
      y_d = y_cur;
      if (line_end && (y_cur != '1)) y_d = y_cur + 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q       <= ST_IDLE;
         x_q           <= '0;
         y_q           <= '0;
         lvld_q        <= 1'b0;
         o_fvld        <= 1'b0;
         o_lvld        <= 1'b0;
         o_dvld        <= 1'b0;
         o_data        <= '0;
         o_frame_start <= 1'b0;
         o_frame_done  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE:  if (!i_fvld) state_q <= ST_WAIT;
            ST_WAIT:  if (i_fvld)  state_q <= ST_FRAME;
            ST_FRAME: if (!i_fvld) state_q <= ST_WAIT;
            default:  state_q <= ST_IDLE;
         endcase
         x_q           <= x_d;
         y_q           <= y_d;
         lvld_q        <= i_lvld & i_fvld;
         o_fvld        <= active & i_fvld;
         o_lvld        <= active & i_fvld & i_lvld & y_in;
         o_dvld        <= beat & x_in & y_in;
         if (beat) o_data <= i_data;
         o_frame_start <= start;
         o_frame_done  <= frame_end;
      end
   end

`ifdef SC2110_ROI_STATS_EN
   logic [CNT_W-1:0] first_w_q, first_w_d, last_w_q, last_w_d;
   logic             have_q, have_d, err_q, err_d;

   always_comb begin
      first_w_d = first_w_q;
      last_w_d  = last_w_q;
      have_d    = have_q;
      err_d     = err_q;
      if (start) begin
         have_d   = 1'b0;
         err_d    = 1'b0;
         last_w_d = '0;
      end
      // Every complete line is compared against the first complete line of the frame.
      if (line_end) begin
         last_w_d = x_q;
         if (!have_q) begin
            have_d    = 1'b1;
            first_w_d = x_q;
         end else if (x_q != first_w_q) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         first_w_q <= '0;
         last_w_q  <= '0;
         have_q    <= 1'b0;
         err_q     <= 1'b0;
         o_width   <= '0;
         o_height  <= '0;
         o_err     <= 1'b0;
      end else begin
         first_w_q <= first_w_d;
         last_w_q  <= last_w_d;
         have_q    <= have_d;
         err_q     <= err_d;
         if (frame_end) begin
            o_width  <= last_w_d;
            o_height <= y_d;
            o_err    <= err_d;
         end
      end
   end
`else
   assign o_width  = '0;
   assign o_height = '0;
   assign o_err    = 1'b0;
`endif

endmodule

// File: doc/sc2110_roi_crop_module.md
# sc2110_roi_crop_module

Window crop and frame-measurement stage for the SC2110 receive path. It sits directly downstream of the SC2110 sync generator and consumes that stage's frame-valid, line-valid, data-valid and 12-bit pixel stream. It forwards only the pixels inside a programmable rectangular region of interest, with regenerated frame and line qualifiers. It also reports per-frame start/done pulses and, optionally, measured line width, frame height and a geometry error flag.

## Interface
Parameters:
- DW, 12, pixel width
- CNT_W, 12, width of x/y counters and measurement outputs
- H_START, 0, first kept pixel index in a line (0-based)
- H_SIZE, 1920, kept pixels per line
- V_START, 0, first kept line index in a frame (0-based)
- V_SIZE, 1080, kept lines per frame

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset; asynchronous, active-low
- i_fvld  in  1  frame valid from sync generator
- i_lvld  in  1  line valid from sync generator
- i_dvld  in  1  pixel valid from sync generator
- i_data  in  DW  pixel
- o_fvld  out  1  cropped frame valid
- o_lvld  out  1  cropped line valid
- o_dvld  out  1  cropped pixel valid
- o_data  out  DW  pixel, registered copy of i_data
- o_frame_start  out  1  one-cycle pulse at accepted frame start
- o_frame_done  out  1  one-cycle pulse at accepted frame end
- o_width  out  CNT_W  pixel count of the last complete line of the last frame
- o_height  out  CNT_W  complete-line count of the last frame
- o_err  out  1  last frame had unequal line widths

## Operation
- State machine:
  - ST_IDLE is entered on reset. It moves to ST_WAIT when i_fvld=0, so any frame in progress at reset release is discarded.
  - ST_WAIT moves to ST_FRAME on an i_fvld rising edge.
  - ST_FRAME moves to ST_WAIT on an i_fvld falling edge.
- Pixel beat: i_dvld & i_lvld & i_fvld while in ST_FRAME.
- x counter:
  - +1 per pixel beat.
  - Cleared on the cycle after i_lvld falls and on frame start.
  - Saturates at 2^CNT_W-1.
- y counter:
  - +1 on each i_lvld falling edge in ST_FRAME.
  - Cleared on frame start.
  - Saturates at 2^CNT_W-1.
- A pixel is in-window when H_START ≤ x < H_START+H_SIZE and V_START ≤ y < V_START+V_SIZE. Compare in CNT_W+1 bits so there is no wrap.
- Outputs:
  - o_dvld = pixel beat & in-window.
  - o_lvld = i_lvld & i_fvld & y in window & ST_FRAME.
  - o_fvld = ST_FRAME & i_fvld.
- i_lvld or i_dvld while i_fvld=0, or outside ST_FRAME, is ignored: no count, no output.
- H_SIZE=0 or V_SIZE=0: o_dvld and o_lvld are never asserted; o_fvld and the pulses still operate.
- A window that extends beyond the real frame produces fewer pixels. This is not an error.
- Line and frame end on the same cycle: the line is counted first, so o_height includes it.

## Timing
- Every output is registered. Latency is exactly 1 cycle from input to o_fvld, o_lvld, o_dvld and o_data.
- o_data loads i_data on every pixel beat and holds otherwise.
- o_frame_start is high in the same cycle as the first high o_fvld.
- o_frame_done is high in the same cycle o_fvld first goes low.
- o_width, o_height and o_err update in the o_frame_done cycle and hold until the next o_frame_done.
- Reset values: all outputs are 0 and the state is ST_IDLE.
- Reset asserted mid-frame: outputs clear immediately (asynchronous). The rest of that frame produces no output.

## Configuration
- SC2110_ROI_STATS_EN defined:
  - Width and height measurement plus o_err are built.
  - o_err = 1 when any complete line in the frame has a pixel count different from the frame's first complete line.
  - A frame with zero lines reports o_err=0.
- SC2110_ROI_STATS_EN undefined:
  - o_width, o_height and o_err are tied to 0 and no measurement registers exist.
  - Crop and pulse behaviour is unchanged.

## Test plan
- Release reset with i_fvld=1 mid-frame: no o_fvld and no o_frame_start until the following i_fvld rising edge; o_frame_done only after that next frame ends.
- 8-line frame, 16 px/line, continuous i_dvld, H_START=2, H_SIZE=4, V_START=1, V_SIZE=3: exactly 12 o_dvld, carrying pixels x=2..5 of lines 1..3. Exactly 3 o_lvld pulses. All outputs 1 cycle after their inputs.
- Same frame with i_dvld high every other cycle: the same 12 pixel values, each 1 cycle after its input beat.
- With SC2110_ROI_STATS_EN: the frame above gives o_width=16, o_height=8, o_err=0 at o_frame_done. Making line 5 only 15 px gives o_err=1; the next clean frame returns o_err=0.
- i_lvld/i_dvld pulses while i_fvld=0: no outputs, and the next frame's o_height is unaffected.
- i_lvld and i_fvld fall on the same cycle on the last line: o_height counts that line (8). o_frame_done fires once.
